// File: rtl/frame_bank_scheduler_pkg.sv
// Shared types and constants for the double-buffered framebuffer scheduler.
// Defaults describe a 240x320 RGB444 panel.
package fb_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } fb_sched_state_t;

    localparam int unsigned DEFAULT_FRAME_WIDTH  = 240;
    localparam int unsigned DEFAULT_FRAME_HEIGHT = 320;
    localparam int unsigned PIXEL_W              = 12;

    function automatic int unsigned frame_pixels(input int unsigned width,
                                                 input int unsigned height);
        return width * height;
    endfunction

    localparam int unsigned DEFAULT_FRAME_PIXELS =
        frame_pixels(DEFAULT_FRAME_WIDTH, DEFAULT_FRAME_HEIGHT);

    // Wide enough to carry every in-frame pixel offset plus out-of-range values.
    localparam int unsigned DEFAULT_WR_ADDR_W = $clog2(DEFAULT_FRAME_PIXELS);

endpackage

// File: rtl/frame_bank_scheduler_if.sv
// Pixel-writer / BRAM-write bundle: the writer drives the pixel stream,
// the scheduler drives the gated BRAM write port.
interface frame_bank_scheduler_if
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned WR_ADDR_W = DEFAULT_WR_ADDR_W
);
    logic                 wr_en_in;
    logic [WR_ADDR_W-1:0] wr_addr_in;
    logic [PIXEL_W-1:0]   wr_data_in;
    logic                 bram_we;
    logic [ADDR_W-1:0]    bram_addr;
    logic [PIXEL_W-1:0]   bram_din;

    modport master (
        output wr_en_in, wr_addr_in, wr_data_in,
        input  bram_we, bram_addr, bram_din
    );

    modport slave (
        input  wr_en_in, wr_addr_in, wr_data_in,
        output bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/frame_bank_scheduler_bank_write_port.sv
// Registered BRAM write port: gates writes, offsets them into the active bank
// and flags out-of-range pixel offsets.
module bank_write_port
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 18,
    parameter int unsigned WR_ADDR_W    = DEFAULT_WR_ADDR_W,
    parameter int unsigned FRAME_PIXELS = DEFAULT_FRAME_PIXELS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 gate_open,
    input  logic                 wr_bank,
    input  logic                 wr_en,
    input  logic [WR_ADDR_W-1:0] wr_addr,
    input  logic [PIXEL_W-1:0]   wr_data,
    output logic                 in_range,
    output logic                 bram_we,
    output logic [ADDR_W-1:0]    bram_addr,
    output logic [PIXEL_W-1:0]   bram_din,
    output logic                 addr_err
);

    logic              accept;
    logic [ADDR_W-1:0] bank_base;

    assign in_range  = (32'(wr_addr) < FRAME_PIXELS);
    assign accept    = wr_en && in_range && gate_open;
    assign bank_base = wr_bank ? ADDR_W'(FRAME_PIXELS) : '0;

    // Address/data hold their last value on gated cycles; only bram_we drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            addr_err  <= 1'b0;
        end else begin
            bram_we <= accept;
            if (accept) begin
                bram_addr <= bank_base + ADDR_W'(wr_addr);
                bram_din  <= wr_data;
            end
            if (wr_en && !in_range) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_bank_scheduler.sv
// Double-buffer controller: writer fills one bank while the display scans the
// other; banks exchange only at display vsync so only whole frames are shown.
module frame_bank_scheduler
    import fb_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
    parameter int unsigned FRAME_HEIGHT = DEFAULT_FRAME_HEIGHT,
    parameter int unsigned ADDR_W       = 18,
    parameter int unsigned WR_ADDR_W    = DEFAULT_WR_ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    frame_bank_scheduler_if.slave         bus,
    input  logic                          wr_frame_done,
    input  logic                          rd_vsync,
    output logic [ADDR_W-1:0]             rd_base,
    output logic                          swap,
    output logic [15:0]                   frames_shown,
    output logic [15:0]                   frames_dropped,
    output logic                          addr_err,
    output logic [1:0]                    state_o
);

    localparam int unsigned FRAME_PIXELS = frame_pixels(FRAME_WIDTH, FRAME_HEIGHT);

    fb_sched_state_t state, state_next;
    logic            wr_bank;
    logic            in_range;
    logic            addr_is_zero;
    logic            gate_open;
    logic            do_swap;
    logic            do_drop;

    assign addr_is_zero = (bus.wr_addr_in == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            SYNC:    if (bus.wr_en_in && in_range && addr_is_zero) state_next = FILL;
            FILL:    if (wr_frame_done)                            state_next = READY;
            READY:   if (rd_vsync)                                 state_next = SYNC;
            default:                                               state_next = SYNC;
        endcase
    end

    // In SYNC only the frame-start write (offset 0) may pass.
    always_comb begin
        gate_open = 1'b0;
        do_swap   = 1'b0;
        do_drop   = 1'b0;
        unique case (state)
            SYNC:    gate_open = addr_is_zero;
            FILL:    gate_open = 1'b1;
            READY: begin
                do_swap = rd_vsync;
                do_drop = wr_frame_done;
            end
            default: gate_open = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank        <= 1'b0;
            swap           <= 1'b0;
            frames_shown   <= '0;
            frames_dropped <= '0;
        end else begin
            swap <= do_swap;
            if (do_swap) begin
                wr_bank      <= !wr_bank;
                frames_shown <= frames_shown + 16'd1;
            end
            if (do_drop) begin
                frames_dropped <= frames_dropped + 16'd1;
            end
        end
    end

    // Display always reads the bank the writer is not filling.
    assign rd_base = wr_bank ? '0 : ADDR_W'(FRAME_PIXELS);
    assign state_o = state;

    bank_write_port #(
        .ADDR_W       (ADDR_W),
        .WR_ADDR_W    (WR_ADDR_W),
        .FRAME_PIXELS (FRAME_PIXELS)
    ) u_write_port (
        .clk       (clk),
        .rst_n     (rst_n),
        .gate_open (gate_open),
        .wr_bank   (wr_bank),
        .wr_en     (bus.wr_en_in),
        .wr_addr   (bus.wr_addr_in),
        .wr_data   (bus.wr_data_in),
        .in_range  (in_range),
        .bram_we   (bus.bram_we),
        .bram_addr (bus.bram_addr),
        .bram_din  (bus.bram_din),
        .addr_err  (addr_err)
    );

endmodule
